// File: rtl/dev_pkg.sv
// -----------------------------------------------------------------------------
// dev_pkg -- shared definitions for the dev_timer device.
//   * word offsets of the CTRL / PRESET / COUNT registers
//   * bit positions of the CTRL fields (Enable, Mode, IM)
//   * Mode encodings (one-shot vs. automatic reload)
//   * FSM state encoding
// -----------------------------------------------------------------------------
package dev_pkg;

  // Register word offsets (Addr = DEV_Addr[3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  // CTRL field positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // Mode encodings; anything other than MODE_RELOAD runs as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/dev_timer.sv
// -----------------------------------------------------------------------------
// dev_timer -- memory-mapped down-counting timer with interrupt request.
//
// Ports:
//   clk      in   1  system clock, all state updates on the rising edge
//   reset    in   1  asynchronous active-low reset
//   Addr     in   2  register word offset (0 CTRL, 1 PRESET, 2 COUNT, 3 reserved)
//   WE       in   1  write enable
//   DataIn   in  32  write data
//   DataOut  out 32  combinational read data of the register selected by Addr
//   IRQ      out  1  registered interrupt request (IM & pending)
//
// Configuration macro: DEV_TIMER_IRQ_EN
//   defined   -> CTRL.IM is writable and IRQ follows IM & pending
//   undefined -> IRQ is tied low, CTRL.IM reads 0; FSM and COUNT unchanged
// -----------------------------------------------------------------------------
module dev_timer
  import dev_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        IRQ
);

  logic        en_q, en_d;
  logic [1:0]  mode_q, mode_d;
  logic        im_q, im_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;
  logic        irq_q, irq_d;
  state_e      state_q, state_d;

  logic        wr_ctrl;
  logic        wr_preset;
  logic        expire;

  assign wr_ctrl   = WE && (Addr == ADDR_CTRL);
  assign wr_preset = WE && (Addr == ADDR_PRESET);
  // Terminal count: COUNT<=1 also covers PRESET=0, which then behaves as 1
  assign expire    = (state_q == ST_CNT) && en_q && (count_q <= 32'd1);

  always_comb begin
    en_d      = en_q;
    mode_d    = mode_q;
    im_d      = im_q;
    preset_d  = preset_q;
    count_d   = count_q;
    pending_d = pending_q;
    state_d   = state_q;

    unique case (state_q)
      ST_IDLE: begin
        if (en_q) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        count_d = preset_q;
        state_d = ST_CNT;
      end
      ST_CNT: begin
        if (!en_q) begin
          state_d = ST_IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d = 32'd0;
          state_d = ST_INT;
        end
      end
      ST_INT: begin
        state_d = ST_IDLE;
        if (mode_q == MODE_RELOAD) begin
          // Reload mode: pending lives for the INT cycle only
          pending_d = 1'b0;
        end else begin
          en_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Bus writes come after the FSM so a CTRL write overrides the
    // one-shot Enable clear landing in the same cycle.
    if (wr_ctrl) begin
      en_d   = DataIn[CTRL_EN_BIT];
      mode_d = DataIn[CTRL_MODE_MSB:CTRL_MODE_LSB];
`ifdef DEV_TIMER_IRQ_EN
      im_d   = DataIn[CTRL_IM_BIT];
`endif
    end
    if (wr_preset) preset_d = DataIn;

    // A CTRL/PRESET write acknowledges pending; a fresh expiry in the same
    // cycle is a newer event and wins.
    if (wr_ctrl || wr_preset) pending_d = 1'b0;
    if (expire)               pending_d = 1'b1;

    // IRQ is registered from the next-state values so it rises on the
    // same edge that enters INT.
`ifdef DEV_TIMER_IRQ_EN
    irq_d = im_d & pending_d;
`else
    irq_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q      <= 1'b0;
      mode_q    <= MODE_ONESHOT;
      im_q      <= 1'b0;
      preset_q  <= 32'd0;
      count_q   <= 32'd0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      en_q      <= en_d;
      mode_q    <= mode_d;
      im_q      <= im_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    DataOut = 32'd0;
    unique case (Addr)
      ADDR_CTRL:   DataOut = {28'd0, im_q, mode_q, en_q};
      ADDR_PRESET: DataOut = preset_q;
      ADDR_COUNT:  DataOut = count_q;
      ADDR_RSVD:   DataOut = 32'd0;
      default:     DataOut = 32'd0;
    endcase
  end

  assign IRQ = irq_q;

endmodule
